jump_encoder: RTL and testbench

JUMP_ENCODER -- requirements
Module: jump_encoder

---
 rtl/jump_encoder.sv | 166 ++++++++++++++++
 tb/tb_jump_encoder.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/jump_encoder.sv
// jump_encoder: turns a destination word address into a J-format jump
// instruction {opcode[5:0], target[25:0]} and queues it in a 2-entry FIFO.
// Destinations that do not fit in 26 bits are queued as err=1 with a nop
// (32'h0) so the consumer sees them in order with the good entries.
// jump_count tracks successfully encoded jumps and saturates at all-ones.
//
// Optional feature: define JUMP_LINK_EN to let link=1 select jal (6'b000011).
// Without it the link port is present but ignored and every entry is j.
//
// State table:
//   state    | meaning
//   ST_EMPTY | no entries queued, head reads as nop
//   ST_ONE   | one entry, held in slot 0 (head)
//   ST_FULL  | two entries, slot 0 is head, slot 1 is next; requests held off
module jump_encoder #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      dest,
  input  logic             link,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      instr,
  output logic             err,
  output logic [CNT_W-1:0] jump_count
);

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JAL = 6'b000011;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [31:0]      slot0_instr_q, slot0_instr_d;
  logic             slot0_err_q,   slot0_err_d;
  logic [31:0]      slot1_instr_q, slot1_instr_d;
  logic             slot1_err_q,   slot1_err_d;
  logic [CNT_W-1:0] jump_count_q,  jump_count_d;

  logic [5:0]  opcode;
  logic        enc_err;
  logic [31:0] enc_instr;
  logic        push;
  logic        pop;

  // Handshake flags come only from registered state, never from out_ready.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef JUMP_LINK_EN
  assign opcode = link ? OP_JAL : OP_J;
`else
  logic unused_link;
  assign unused_link = link;
  assign opcode      = OP_J;
`endif

  // Encode the incoming destination; anything above 26 bits is rejected
  // outright rather than truncated, so a good entry always decodes back.
  always_comb begin
    enc_err   = (dest[31:26] != 6'd0);
    enc_instr = 32'h0;
    if (!enc_err) begin
      enc_instr = {opcode, dest[25:0]};
    end
  end

  // FIFO occupancy, slot shuffling and the saturating good-jump counter.
  always_comb begin
    state_d       = state_q;
    slot0_instr_d = slot0_instr_q;
    slot0_err_d   = slot0_err_q;
    slot1_instr_d = slot1_instr_q;
    slot1_err_d   = slot1_err_q;
    jump_count_d  = jump_count_q;

    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          slot0_instr_d = enc_instr;
          slot0_err_d   = enc_err;
          state_d       = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          // Head leaves, new entry takes its place directly.
          slot0_instr_d = enc_instr;
          slot0_err_d   = enc_err;
        end else if (push) begin
          slot1_instr_d = enc_instr;
          slot1_err_d   = enc_err;
          state_d       = ST_FULL;
        end else if (pop) begin
          // Clearing keeps an empty head reading as nop.
          slot0_instr_d = 32'h0;
          slot0_err_d   = 1'b0;
          state_d       = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // push cannot happen here since in_ready is low.
        if (pop) begin
          slot0_instr_d = slot1_instr_q;
          slot0_err_d   = slot1_err_q;
          slot1_instr_d = 32'h0;
          slot1_err_d   = 1'b0;
          state_d       = ST_ONE;
        end
      end
      default: begin
        state_d       = ST_EMPTY;
        slot0_instr_d = 32'h0;
        slot0_err_d   = 1'b0;
        slot1_instr_d = 32'h0;
        slot1_err_d   = 1'b0;
      end
    endcase

    if (push && !enc_err && (jump_count_q != {CNT_W{1'b1}})) begin
      jump_count_d = jump_count_q + 1'b1;
    end
  end

  // State register with synchronous reset; reset wins over any request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_EMPTY;
      slot0_instr_q <= 32'h0;
      slot0_err_q   <= 1'b0;
      slot1_instr_q <= 32'h0;
      slot1_err_q   <= 1'b0;
      jump_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      slot0_instr_q <= slot0_instr_d;
      slot0_err_q   <= slot0_err_d;
      slot1_instr_q <= slot1_instr_d;
      slot1_err_q   <= slot1_err_d;
      jump_count_q  <= jump_count_d;
    end
  end

  // Head outputs are forced to nop while empty.
  always_comb begin
    instr = 32'h0;
    err   = 1'b0;
    if (out_valid) begin
      instr = slot0_instr_q;
      err   = slot0_err_q;
    end
  end

  assign jump_count = jump_count_q;

endmodule

// File: tb/tb_jump_encoder.sv
// Bench for jump_encoder: directed cases plus random traffic, all compared
// against a queue-based reference model. A narrow counter keeps the
// saturation case short.
module tb_jump_encoder;

  localparam int CNT_W = 4;
  localparam int JMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      dest;
  logic             link;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      instr;
  logic             err;
  logic [CNT_W-1:0] jump_count;

  always #5 clk = ~clk;

  jump_encoder #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dest       (dest),
    .link       (link),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .instr      (instr),
    .err        (err),
    .jump_count (jump_count)
  );

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } ent_t;

  ent_t mq[$];
  int   jc_m = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ent_t encode(input logic [31:0] d, input logic l);
    ent_t e;
    int unsigned op;
    op = 2;
`ifdef JUMP_LINK_EN
    if (l) op = 3;
`else
    if (l) op = 2;
`endif
    if (d > 32'h03FF_FFFF) begin
      e.err   = 1'b1;
      e.instr = 32'h0;
    end else begin
      e.err   = 1'b0;
      e.instr = op * 32'h0400_0000 + d;
    end
    return e;
  endfunction

  task automatic compare_outputs();
    check_val("in_ready",   {31'd0, in_ready},  {31'd0, mq.size() < 2});
    check_val("out_valid",  {31'd0, out_valid}, {31'd0, mq.size() > 0});
    check_val("instr",      instr, (mq.size() > 0) ? mq[0].instr : 32'h0);
    check_val("err",        {31'd0, err}, (mq.size() > 0) ? {31'd0, mq[0].err} : 32'd0);
    check_val("jump_count", 32'(jump_count), 32'(jc_m));
  endtask

  // One clock: drive at negedge, compare, then advance the model at posedge.
  task automatic step(input logic rst, input logic iv, input logic [31:0] d,
                      input logic lk, input logic ordy);
    bit   acc;
    bit   pop;
    ent_t e;
    @(negedge clk);
    reset     = rst;
    in_valid  = iv;
    dest      = d;
    link      = lk;
    out_ready = ordy;
    compare_outputs();
    @(posedge clk);
    if (rst) begin
      mq.delete();
      jc_m = 0;
    end else begin
      acc = iv && (mq.size() < 2);
      pop = ordy && (mq.size() > 0);
      if (pop) void'(mq.pop_front());
      if (acc) begin
        e = encode(d, lk);
        mq.push_back(e);
        if (!e.err && jc_m < JMAX) jc_m++;
      end
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp36;
    ent_t        ea;

    reset = 1'b1; in_valid = 1'b0; dest = 32'h0; link = 1'b0; out_ready = 1'b0;

    step(1, 0, 0, 0, 0);
    step(1, 1, 32'h10, 0, 1);
    #1;
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check_val("rst_instr",     instr, 32'h0);
    check_val("rst_err",       {31'd0, err}, 32'd0);
    check_val("rst_jc",        32'(jump_count), 32'd0);

    // Basic j encode with one-cycle latency.
    step(0, 1, 32'h0000_0040, 0, 0);
    #1;
    check_val("j40_valid", {31'd0, out_valid}, 32'd1);
    check_val("j40_instr", instr, 32'h0800_0040);
    check_val("j40_err",   {31'd0, err}, 32'd0);
    check_val("j40_jc",    32'(jump_count), 32'd1);
    step(0, 0, 0, 0, 1);

    // First out-of-range destination.
    step(0, 1, 32'h0400_0000, 0, 0);
    #1;
    check_val("oor_instr", instr, 32'h0);
    check_val("oor_err",   {31'd0, err}, 32'd1);
    check_val("oor_jc",    32'(jump_count), 32'd1);
    step(0, 0, 0, 0, 1);

    // Backpressure: two queue, third held off, then drain in order.
    step(0, 1, 32'h0000_1111, 0, 0);
    step(0, 1, 32'h0222_2222, 0, 0);
    #1;
    check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
    step(0, 1, 32'h0033_3333, 0, 0);
    #1;
    check_val("bp_head", instr, 32'h0800_1111);
    step(0, 0, 0, 0, 1);
    #1;
    check_val("bp_second", instr, 32'h0A22_2222);
    step(0, 0, 0, 0, 1);
    #1;
    check_val("bp_drained", {31'd0, out_valid}, 32'd0);

    // Push and pop together with one entry queued.
    step(0, 1, 32'h0000_0ABC, 0, 0);
    step(0, 1, 32'h0123_4567, 0, 1);
    #1;
    check_val("pp_valid",    {31'd0, out_valid}, 32'd1);
    check_val("pp_in_ready", {31'd0, in_ready},  32'd1);
    check_val("pp_decode",   {6'd0, instr[25:0]}, 32'h0123_4567);
    step(0, 0, 0, 0, 1);

    // Largest encodable target with link requested.
`ifdef JUMP_LINK_EN
    exp36 = 32'h0FFF_FFFF;
`else
    exp36 = 32'h0BFF_FFFF;
`endif
    step(0, 1, 32'h03FF_FFFF, 1, 0);
    #1;
    check_val("max_link_instr", instr, exp36);
    step(0, 0, 0, 0, 1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      d = $urandom;
      if ($urandom_range(0, 3) != 0) d[31:26] = 6'd0;
      if ($urandom_range(0, 15) == 0) d = ($urandom_range(0, 1) != 0) ? 32'h03FF_FFFF : 32'h0400_0000;
      step(($urandom_range(0, 49) == 0), $urandom_range(0, 1), d,
           $urandom_range(0, 1), $urandom_range(0, 2) != 0);
    end

    // Saturation of the good-jump counter.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < JMAX; i++) begin
      step(0, 1, 32'(i * 4), 0, 1);
    end
    #1;
    check_val("sat_reach", 32'(jump_count), 32'(JMAX));
    step(0, 1, 32'h0000_0100, 0, 1);
    #1;
    check_val("sat_hold", 32'(jump_count), 32'(JMAX));
    step(0, 0, 0, 0, 1);

    // Reset with the FIFO full and a request pending.
    step(0, 1, 32'h0000_0200, 0, 0);
    step(0, 1, 32'h0000_0300, 0, 0);
    #1;
    check_val("full_in_ready", {31'd0, in_ready}, 32'd0);
    ea = encode(32'h0000_0200, 0);
    check_val("full_head", instr, ea.instr);
    step(1, 1, 32'h0000_0400, 0, 0);
    #1;
    check_val("rstfull_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rstfull_in_ready",  {31'd0, in_ready},  32'd1);
    check_val("rstfull_instr",     instr, 32'h0);
    check_val("rstfull_jc",        32'(jump_count), 32'd0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
